doraemon_feeder: RTL

// - clk1-domain front end for the doraemon CDC/scoring stage. Buffers records from a producer (valid/ready).
// - Issues records to the CDC stage using the CDC input protocol:
//   - an initial burst of N_FILL back-to-back records (door fill);
//   - then N_RUN further records, each only while downstream ready is high.
// - Guarantees the fill burst is never broken by a producer stall.

---
 rtl/doraemon_feeder_pkg.sv | 28 ++
 rtl/feeder_fifo.sv | 47 ++++
 rtl/doraemon_feeder.sv | 116 +++++++++++
 3 files changed

// File: rtl/doraemon_feeder_pkg.sv
// Shared record layout, fill length and FSM encoding for the doraemon feeder.
package doraemon_feeder_pkg;

  localparam int ID_W   = 5;
  localparam int SC_W   = 8;
  localparam int WT_W   = 3;
  localparam int REC_W  = ID_W + 3 * SC_W + 3 * WT_W;  // 38
  localparam int N_FILL = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Packed as {id,size,iq,eq,sw,iqw,eqw}, id in the MSBs.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [SC_W-1:0] size;
    logic [SC_W-1:0] iq;
    logic [SC_W-1:0] eq;
    logic [WT_W-1:0] sw;
    logic [WT_W-1:0] iqw;
    logic [WT_W-1:0] eqw;
  } rec_t;

endpackage

// File: rtl/feeder_fifo.sv
// Single-clock FIFO: registered pointers/occupancy, combinational head read.
// The caller must never push when full or pop when empty.
module feeder_fifo
  import doraemon_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = REC_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/doraemon_feeder.sv
// clk1-side feeder: buffers producer records, issues an unbroken N_FILL burst,
// then N_RUN more records under dst_ready flow control, then parks in DONE.
module doraemon_feeder
  import doraemon_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int N_RUN = 5995
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            src_valid,
  output logic            src_ready,
  input  logic [ID_W-1:0] src_id,
  input  logic [SC_W-1:0] src_size,
  input  logic [SC_W-1:0] src_iq,
  input  logic [SC_W-1:0] src_eq,
  input  logic [WT_W-1:0] src_sw,
  input  logic [WT_W-1:0] src_iqw,
  input  logic [WT_W-1:0] src_eqw,
  input  logic            dst_ready,
  output logic            in_valid,
  output logic [ID_W-1:0] doraemon_id,
  output logic [SC_W-1:0] size,
  output logic [SC_W-1:0] iq_score,
  output logic [SC_W-1:0] eq_score,
  output logic [WT_W-1:0] size_weight,
  output logic [WT_W-1:0] iq_weight,
  output logic [WT_W-1:0] eq_weight,
  output logic [12:0]     run_cnt,
  output logic            done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(N_FILL + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] FILL_LVL = CW'(N_FILL);
  localparam logic [FW-1:0] FILL_END = FW'(N_FILL - 1);
  localparam logic [12:0]   RUN_END  = 13'(N_RUN - 1);

  state_t        state;
  logic [FW-1:0] fill_cnt;
  logic [CW-1:0] count;
  logic          push, pop;
  rec_t          wrec, head, out_r;

  // Depends only on registered count/state, so a pop cannot make room in
  // the same cycle.
  assign src_ready = (count < FULL_LVL) && (state != DONE);
  assign push      = src_valid && src_ready;
  assign wrec      = '{id: src_id, size: src_size, iq: src_iq, eq: src_eq,
                       sw: src_sw, iqw: src_iqw, eqw: src_eqw};

  // Pop decision. FILL ignores dst_ready: IDLE only leaves once N_FILL
  // records are buffered, so the burst can never run dry.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count >= FILL_LVL);
      FILL:    pop = 1'b1;
      RUN:     pop = dst_ready && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  feeder_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk1  (clk1),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wrec),
    .rdata (head),
    .count (count)
  );

  // FSM, counters and registered issue stage; idle cycles drive zeros.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fill_cnt <= '0;
      run_cnt  <= '0;
      done     <= 1'b0;
      in_valid <= 1'b0;
      out_r    <= '0;
    end else begin
      in_valid <= pop;
      out_r    <= pop ? head : '0;
      case (state)
        IDLE: if (pop) begin
          fill_cnt <= FW'(1);
          state    <= FILL;
        end
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == FILL_END) state <= RUN;
        end
        RUN: if (pop) begin
          run_cnt <= run_cnt + 13'd1;
          if (run_cnt == RUN_END) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign doraemon_id = out_r.id;
  assign size        = out_r.size;
  assign iq_score    = out_r.iq;
  assign eq_score    = out_r.eq;
  assign size_weight = out_r.sw;
  assign iq_weight   = out_r.iqw;
  assign eq_weight   = out_r.eqw;

endmodule
